// File: rtl/fp16_pkg.sv
// fp16_pkg
// Shared definitions for the FP16 issue controller:
//   - fp16_op_e       : request opcode encoding (ADD, SUB, MUL, RSVD)
//   - issue_state_e   : issue controller FSM states
//   - FP16_CANON_QNAN : canonical quiet NaN returned for invalid operations
//   - FLAG_*          : bit positions inside the {NV,DZ,OF,UF,NX} flag vector
//   - fp16_class_t    : operand classification, filled in by fp16_classify()
package fp16_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_RSVD = 2'd3
  } fp16_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_DISPATCH,
    ST_WAIT,
    ST_RESP
  } issue_state_e;

  localparam logic [15:0] FP16_CANON_QNAN = 16'h7E00;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef struct packed {
    logic sign;
    logic is_qnan;
    logic is_snan;
    logic is_zero;
    logic is_inf;
    logic is_sub;
    logic is_norm;
  } fp16_class_t;

  // The quiet bit is the top mantissa bit; a NaN with it clear is signalling.
  function automatic fp16_class_t fp16_classify(input logic [15:0] x);
    fp16_class_t c;
    logic exp_max;
    logic exp_zero;
    logic man_zero;
    exp_max   = (x[14:10] == 5'h1F);
    exp_zero  = (x[14:10] == 5'h00);
    man_zero  = (x[9:0] == 10'h000);
    c.sign    = x[15];
    c.is_qnan = exp_max && !man_zero && x[9];
    c.is_snan = exp_max && !man_zero && !x[9];
    c.is_inf  = exp_max && man_zero;
    c.is_zero = exp_zero && man_zero;
    c.is_sub  = exp_zero && !man_zero;
    c.is_norm = !exp_max && !exp_zero;
    return c;
  endfunction

endpackage

// File: rtl/fp16_rr_arb.sv
// fp16_rr_arb
// Round-robin arbiter for the issue controller. The search for the next
// winner starts one position after the last granted requester and wraps.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : request vector (already qualified by the caller)
//   update      : pulse when the current grant is actually taken
//   grant       : one-hot grant (all zero when nothing requests)
//   grant_idx   : index of the granted requester
//   grant_any   : at least one requester is granted
module fp16_rr_arb #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            update,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  logic [ID_W-1:0] last_grant;
  logic [ID_W:0]   cand;

  // Walk from the farthest candidate to the nearest one so the nearest
  // requester after last_grant overwrites any earlier hit.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = {1'b0, last_grant} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end
      if (req[cand[ID_W-1:0]]) begin
        grant_idx = cand[ID_W-1:0];
        grant_any = 1'b1;
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Starting at NREQ-1 makes requester 0 the first winner after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NREQ - 1);
    end else if (update) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/fp16_issue_ctrl.sv
// fp16_issue_ctrl
// Issue controller for the FP16 arithmetic unit. Arbitrates add/sub/mul
// requests from NREQ requesters, resolves special operands locally and sends
// the rest to the shared multi-cycle execution unit. One operation in flight.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready        : per-requester request handshake
//   req_op, req_a, req_b       : per-requester op (2b) and FP16 operands
//   ex_valid/ex_ready          : dispatch handshake to the execution unit
//   ex_op, ex_a, ex_b          : captured op and operands
//   ex_rsp_valid/result/flags  : execution unit result pulse
//   rsp_valid/rsp_ready        : response handshake
//   rsp_id, rsp_result, rsp_flags : requester index, result, {NV,DZ,OF,UF,NX}
//   busy                       : controller is not idle
// Configuration macro FP16_SPECIAL_BYPASS_EN: when defined, NaN/inf/zero
// operand cases are resolved here; otherwise only the reserved op is.
module fp16_issue_ctrl
  import fp16_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [2*NREQ-1:0]  req_op,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [1:0]         ex_op,
  output logic [15:0]        ex_a,
  output logic [15:0]        ex_b,
  input  logic               ex_rsp_valid,
  input  logic [15:0]        ex_rsp_result,
  input  logic [4:0]         ex_rsp_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [15:0]        rsp_result,
  output logic [4:0]         rsp_flags,
  output logic               busy
);

  issue_state_e    state, state_next;
  logic [NREQ-1:0] arb_req;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic            accept;
  logic            special_hit;
  logic [15:0]     special_result;
  logic [4:0]      special_flags;

  // Requests are only visible to the arbiter while idle, so req_ready is
  // naturally zero in every other state.
  assign arb_req   = (state == ST_IDLE) ? req_valid : '0;
  assign accept    = (state == ST_IDLE) && grant_any;
  assign req_ready = grant;

  fp16_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (arb_req),
    .update    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

`ifdef FP16_SPECIAL_BYPASS_EN
  fp16_class_t ca, cb;
  logic        sb_eff;
  logic        is_add;
  assign ca     = fp16_classify(ex_a);
  assign cb     = fp16_classify(ex_b);
  assign sb_eff = cb.sign ^ (ex_op == OP_SUB);
  assign is_add = (ex_op == OP_ADD) || (ex_op == OP_SUB);
`endif

  // Special-case resolution on the captured operands, first match wins.
  // SUB is handled as ADD with the sign of b inverted.
  always_comb begin
    special_hit    = 1'b0;
    special_result = FP16_CANON_QNAN;
    special_flags  = '0;
    if (ex_op == OP_RSVD) begin
      special_hit            = 1'b1;
      special_flags[FLAG_NV] = 1'b1;
    end
`ifdef FP16_SPECIAL_BYPASS_EN
    else if (ca.is_snan || cb.is_snan) begin
      special_hit            = 1'b1;
      special_flags[FLAG_NV] = 1'b1;
    end else if (ca.is_qnan || cb.is_qnan) begin
      special_hit = 1'b1;
    end else if (is_add) begin
      if (ca.is_inf && cb.is_inf && (ca.sign != sb_eff)) begin
        special_hit            = 1'b1;
        special_flags[FLAG_NV] = 1'b1;
      end else if (ca.is_inf) begin
        special_hit    = 1'b1;
        special_result = {ca.sign, 15'h7C00};
      end else if (cb.is_inf) begin
        special_hit    = 1'b1;
        special_result = {sb_eff, 15'h7C00};
      end
    end else begin
      if ((ca.is_inf && cb.is_zero) || (ca.is_zero && cb.is_inf)) begin
        special_hit            = 1'b1;
        special_flags[FLAG_NV] = 1'b1;
      end else if (ca.is_inf || cb.is_inf) begin
        special_hit    = 1'b1;
        special_result = {ca.sign ^ cb.sign, 15'h7C00};
      end else if (ca.is_zero || cb.is_zero) begin
        special_hit    = 1'b1;
        special_result = {ca.sign ^ cb.sign, 15'h0000};
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ex_rsp_valid only matters in WAIT; pulses seen elsewhere are dropped.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (grant_any) state_next = ST_CLASSIFY;
      ST_CLASSIFY: state_next = special_hit ? ST_RESP : ST_DISPATCH;
      ST_DISPATCH: if (ex_valid && ex_ready) state_next = ST_WAIT;
      ST_WAIT:     if (ex_rsp_valid) state_next = ST_RESP;
      ST_RESP:     if (rsp_valid && rsp_ready) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe without any combinational path to the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      rsp_valid  <= 1'b0;
      busy       <= 1'b0;
      ex_op      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      ex_valid  <= (state_next == ST_DISPATCH);
      rsp_valid <= (state_next == ST_RESP);
      busy      <= (state_next != ST_IDLE);
      if (accept) begin
        ex_op  <= req_op[2*grant_idx +: 2];
        ex_a   <= req_a[16*grant_idx +: 16];
        ex_b   <= req_b[16*grant_idx +: 16];
        rsp_id <= grant_idx;
      end
      if ((state == ST_CLASSIFY) && special_hit) begin
        rsp_result <= special_result;
        rsp_flags  <= special_flags;
      end
      if ((state == ST_WAIT) && ex_rsp_valid) begin
        rsp_result <= ex_rsp_result;
        rsp_flags  <= ex_rsp_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp16_issue_ctrl.sv
// tb_fp16_issue_ctrl
// Self-checking bench for fp16_issue_ctrl with two requesters. Requesters and
// the execution unit are modelled by background processes; expected responses
// are queued when a request is accepted and compared on each response.
module tb_fp16_issue_ctrl;

  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [2*NREQ-1:0]  req_op;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic               ex_valid;
  logic               ex_ready;
  logic [1:0]         ex_op;
  logic [15:0]        ex_a;
  logic [15:0]        ex_b;
  logic               ex_rsp_valid;
  logic [15:0]        ex_rsp_result;
  logic [4:0]         ex_rsp_flags;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [15:0]        rsp_result;
  logic [4:0]         rsp_flags;
  logic               busy;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     res;
    logic [4:0]      flags;
  } exp_t;

  req_t            pend0[$];
  req_t            pend1[$];
  exp_t            sb[$];
  logic [ID_W-1:0] rsp_log[$];
  int errors  = 0;
  int checks  = 0;
  int exv_cnt = 0;
  int rspv_cnt = 0;
  int eu_lat  = 2;

  fp16_issue_ctrl #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_a         (req_a),
    .req_b         (req_b),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_op         (ex_op),
    .ex_a          (ex_a),
    .ex_b          (ex_b),
    .ex_rsp_valid  (ex_rsp_valid),
    .ex_rsp_result (ex_rsp_result),
    .ex_rsp_flags  (ex_rsp_flags),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_flags     (rsp_flags),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Execution unit behaviour: one known-correct sum, otherwise a scramble of
  // the operands so that any corruption of ex_* shows up in the result.
  function automatic logic [20:0] eu_func(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    if (op == 2'd0 && a == 16'h3C00 && b == 16'h4000) return {16'h4200, 5'b00000};
    return {a ^ {b[7:0], b[15:8]} ^ {14'h0, op}, a[4:0] ^ b[4:0] ^ 5'b00101};
  endfunction

`ifdef FP16_SPECIAL_BYPASS_EN
  // Reference for the local special-case rules: {hit, result, flags}.
  function automatic logic [21:0] ref_special(input req_t r);
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sbx;
    a_nan  = (r.a[14:10] == 5'h1F) && (r.a[9:0] != 0);
    b_nan  = (r.b[14:10] == 5'h1F) && (r.b[9:0] != 0);
    a_snan = a_nan && !r.a[9];
    b_snan = b_nan && !r.b[9];
    a_inf  = (r.a[14:0] == 15'h7C00);
    b_inf  = (r.b[14:0] == 15'h7C00);
    a_zero = (r.a[14:0] == 15'h0000);
    b_zero = (r.b[14:0] == 15'h0000);
    sbx    = r.b[15] ^ (r.op == 2'd1);
    if (r.op == 2'd3) return {1'b1, 16'h7E00, 5'b10000};
    if (a_snan || b_snan) return {1'b1, 16'h7E00, 5'b10000};
    if (a_nan || b_nan) return {1'b1, 16'h7E00, 5'b00000};
    if (r.op != 2'd2) begin
      if (a_inf && b_inf && (r.a[15] != sbx)) return {1'b1, 16'h7E00, 5'b10000};
      if (a_inf) return {1'b1, r.a[15], 15'h7C00, 5'b00000};
      if (b_inf) return {1'b1, sbx, 15'h7C00, 5'b00000};
    end else begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) return {1'b1, 16'h7E00, 5'b10000};
      if (a_inf || b_inf) return {1'b1, r.a[15] ^ r.b[15], 15'h7C00, 5'b00000};
      if (a_zero || b_zero) return {1'b1, r.a[15] ^ r.b[15], 15'h0000, 5'b00000};
    end
    return 22'h0;
  endfunction
`endif

  function automatic exp_t make_exp(input logic [ID_W-1:0] id, input req_t r);
    logic [20:0] rf;
`ifdef FP16_SPECIAL_BYPASS_EN
    logic [21:0] sp;
    sp = ref_special(r);
    rf = sp[21] ? sp[20:0] : eu_func(r.op, r.a, r.b);
`else
    rf = (r.op == 2'd3) ? {16'h7E00, 5'b10000} : eu_func(r.op, r.a, r.b);
`endif
    return {id, rf};
  endfunction

  // Requester model: presents the head of each queue and retires it once
  // accepted, recording the expected response at that moment.
  initial begin
    logic acc0, acc1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    forever begin
      @(negedge clk);
      acc0 = rst_n && req_valid[0] && req_ready[0];
      acc1 = rst_n && req_valid[1] && req_ready[1];
      if (acc0 && pend0.size() > 0) sb.push_back(make_exp(1'b0, pend0[0]));
      if (acc1 && pend1.size() > 0) sb.push_back(make_exp(1'b1, pend1[0]));
      @(posedge clk);
      #1;
      if (acc0 && pend0.size() > 0) void'(pend0.pop_front());
      if (acc1 && pend1.size() > 0) void'(pend1.pop_front());
      req_valid[0] = (pend0.size() > 0);
      req_valid[1] = (pend1.size() > 0);
      if (pend0.size() > 0) begin
        req_op[1:0] = pend0[0].op; req_a[15:0] = pend0[0].a; req_b[15:0] = pend0[0].b;
      end
      if (pend1.size() > 0) begin
        req_op[3:2] = pend1[0].op; req_a[31:16] = pend1[0].a; req_b[31:16] = pend1[0].b;
      end
    end
  end

  // Execution unit model: answers each dispatch after eu_lat cycles.
  initial begin
    logic [20:0] r;
    ex_rsp_valid  = 1'b0;
    ex_rsp_result = '0;
    ex_rsp_flags  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ex_valid && ex_ready) begin
        r = eu_func(ex_op, ex_a, ex_b);
        @(posedge clk);
        #1;
        repeat (eu_lat - 1) begin
          @(posedge clk);
          #1;
        end
        ex_rsp_valid  = 1'b1;
        ex_rsp_result = r[20:5];
        ex_rsp_flags  = r[4:0];
        @(posedge clk);
        #1;
        ex_rsp_valid = 1'b0;
      end
    end
  end

  // Response scoreboard and the busy/req_ready interlock.
  always @(negedge clk) begin
    exp_t e;
    if (ex_valid) exv_cnt++;
    if (rsp_valid) rspv_cnt++;
    if (busy) begin
      checks++;
      if (req_ready !== '0) begin
        errors++;
        $display("[TB] FAIL ready_while_busy: req_ready=%b want 00", req_ready);
      end
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      rsp_log.push_back(rsp_id);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL rsp_unexpected: id=%0d res=%h with no request outstanding",
                 rsp_id, rsp_result);
      end else begin
        e = sb.pop_front();
        if ({rsp_id, rsp_result, rsp_flags} !== e) begin
          errors++;
          $display("[TB] FAIL rsp_data: got id=%0d res=%h flags=%b want id=%0d res=%h flags=%b",
                   rsp_id, rsp_result, rsp_flags, e.id, e.res, e.flags);
        end
      end
    end
  end

  task automatic applyStimulus(input int who, input logic [1:0] op, input logic [15:0] a,
                               input logic [15:0] b);
    req_t r;
    r = '{op: op, a: a, b: b};
    if (who == 0) pend0.push_back(r);
    else pend1.push_back(r);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (pend0.size() == 0 && pend1.size() == 0 && sb.size() == 0 && !busy && !rsp_valid)
        done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain_timeout: pending=%0d/%0d sb=%0d busy=%b want all idle",
               pend0.size(), pend1.size(), sb.size(), busy);
    end
  endtask

  task automatic wait_grant(input int who);
    bit found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (req_ready[who]) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL grant_timeout: requester %0d never granted", who);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0; ex_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 10;
    if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: %b want 00", req_ready); end
    if (ex_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_ex_valid: %b want 0", ex_valid); end
    if (rsp_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_rsp_valid: %b want 0", rsp_valid); end
    if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: %b want 0", busy); end
    if (ex_op !== 2'd0)      begin errors++; $display("[TB] FAIL reset_ex_op: %h want 0", ex_op); end
    if (ex_a !== 16'h0)      begin errors++; $display("[TB] FAIL reset_ex_a: %h want 0", ex_a); end
    if (ex_b !== 16'h0)      begin errors++; $display("[TB] FAIL reset_ex_b: %h want 0", ex_b); end
    if (rsp_id !== 1'b0)     begin errors++; $display("[TB] FAIL reset_rsp_id: %h want 0", rsp_id); end
    if (rsp_result !== 16'h0) begin errors++; $display("[TB] FAIL reset_rsp_result: %h want 0", rsp_result); end
    if (rsp_flags !== 5'h0)  begin errors++; $display("[TB] FAIL reset_rsp_flags: %b want 0", rsp_flags); end
    rst_n = 1'b1; rsp_ready = 1'b1; ex_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_special_mul();
    int exv0;
    exv0 = exv_cnt;
    eu_lat = 2;
    applyStimulus(0, 2'd2, 16'h7C00, 16'h0000);
    wait_grant(0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL classify_busy: %b want 1", busy); end
    @(negedge clk);
`ifdef FP16_SPECIAL_BYPASS_EN
    checks += 3;
    if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL special_latency: rsp_valid=%b want 1", rsp_valid); end
    if (rsp_result !== 16'h7E00) begin errors++; $display("[TB] FAIL special_result: %h want 7e00", rsp_result); end
    if (rsp_flags !== 5'b10000) begin errors++; $display("[TB] FAIL special_flags: %b want 10000", rsp_flags); end
    wait_drain();
    checks++;
    if (exv_cnt != exv0) begin errors++; $display("[TB] FAIL special_no_dispatch: ex_valid cycles=%0d want 0", exv_cnt - exv0); end
`else
    checks += 2;
    if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL dispatch_latency: ex_valid=%b want 1", ex_valid); end
    if (ex_a !== 16'h7C00) begin errors++; $display("[TB] FAIL dispatch_ex_a: %h want 7c00", ex_a); end
    wait_drain();
`endif
  endtask

  task automatic test_exec_add();
    bit seen = 0;
    eu_lat = 3;
    applyStimulus(1, 2'd0, 16'h3C00, 16'h4000);
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ex_rsp_valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL exec_timeout: no ex_rsp_valid"); end
    @(negedge clk);
    checks += 3;
    if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL exec_rsp_latency: rsp_valid=%b want 1", rsp_valid); end
    if (rsp_id !== 1'b1) begin errors++; $display("[TB] FAIL exec_rsp_id: %0d want 1", rsp_id); end
    if (rsp_result !== 16'h4200) begin errors++; $display("[TB] FAIL exec_rsp_result: %h want 4200", rsp_result); end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    rsp_log.delete();
    eu_lat = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 2'd0, 16'h3C00 + 16'(i), 16'h3800);
      applyStimulus(1, 2'd0, 16'h4000 + 16'(i), 16'h3400);
    end
    wait_drain();
    checks++;
    if (rsp_log.size() != 8) begin errors++; $display("[TB] FAIL b2b_count: %0d responses want 8", rsp_log.size()); end
    for (int i = 0; i < 8 && i < rsp_log.size(); i++) begin
      checks++;
      if (rsp_log[i] !== ID_W'(i % 2)) begin
        errors++;
        $display("[TB] FAIL b2b_order[%0d]: id=%0d want %0d", i, rsp_log[i], i % 2);
      end
    end
  endtask

  task automatic test_rsvd_and_sub();
    int exv0;
    exv0 = exv_cnt;
    applyStimulus(1, 2'd3, 16'h3C00, 16'h3C00);
    wait_drain();
    checks++;
    if (exv_cnt != exv0) begin errors++; $display("[TB] FAIL rsvd_no_dispatch: ex_valid cycles=%0d want 0", exv_cnt - exv0); end
    exv0 = exv_cnt;
    applyStimulus(0, 2'd1, 16'h7C00, 16'h7C00);
    applyStimulus(0, 2'd1, 16'hFC00, 16'h3C00);
    wait_drain();
`ifdef FP16_SPECIAL_BYPASS_EN
    checks++;
    if (exv_cnt != exv0) begin errors++; $display("[TB] FAIL sub_no_dispatch: ex_valid cycles=%0d want 0", exv_cnt - exv0); end
`endif
  endtask

  task automatic test_stall();
    bit seen = 0;
    logic [20:0] r;
    r = eu_func(2'd2, 16'h4000, 16'h4200);
    ex_ready = 1'b0; rsp_ready = 1'b0; eu_lat = 1;
    applyStimulus(0, 2'd2, 16'h4000, 16'h4200);
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ex_valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL stall_dispatch_timeout: no ex_valid"); end
    applyStimulus(1, 2'd0, 16'h3C00, 16'h3C00);
    for (int k = 0; k < 4; k++) begin
      checks += 2;
      if ({ex_valid, ex_op, ex_a, ex_b} !== {1'b1, 2'd2, 16'h4000, 16'h4200}) begin
        errors++;
        $display("[TB] FAIL ex_stall: valid=%b op=%0d a=%h b=%h want 1 2 4000 4200", ex_valid, ex_op, ex_a, ex_b);
      end
      if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL ex_stall_ready: %b want 00", req_ready); end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL stall_rsp_timeout: no rsp_valid"); end
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b0, r}) begin
        errors++;
        $display("[TB] FAIL rsp_stall: valid=%b id=%0d res=%h flags=%b want 1 0 %h %b",
                 rsp_valid, rsp_id, rsp_result, rsp_flags, r[20:5], r[4:0]);
      end
      if (req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rsp_stall_ready: %b want 00", req_ready); end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int rv0;
    eu_lat = 6; ex_ready = 1'b1; rsp_ready = 1'b1;
    applyStimulus(0, 2'd0, 16'h4400, 16'h3C00);
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ex_valid && ex_ready) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("[TB] FAIL mid_dispatch_timeout: no dispatch"); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_busy: %b want 0", busy); end
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_rsp_valid: %b want 0", rsp_valid); end
    if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ex_valid: %b want 0", ex_valid); end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rv0 = rspv_cnt;
    repeat (8) @(negedge clk);
    checks += 2;
    if (rspv_cnt != rv0) begin errors++; $display("[TB] FAIL late_rsp_ignored: rsp_valid cycles=%0d want 0", rspv_cnt - rv0); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL late_rsp_busy: %b want 0", busy); end
    eu_lat = 2;
    applyStimulus(1, 2'd0, 16'h3C00, 16'h4000);
    wait_grant(1);
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_special_mul();
    test_exec_add();
    test_back_to_back();
    test_rsvd_and_sub();
    test_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp16_issue_ctrl.md
# fp16_issue_ctrl

Issue controller for the FP16 arithmetic unit. It accepts add, sub and mul requests from NREQ requesters and picks one with round-robin arbitration. It classifies both operands and resolves NaN/infinity/zero special cases locally; all other cases go to the shared multi-cycle execution unit. Each result returns with its requester ID over a valid/ready response port.

## Interface
- NREQ, 2, number of requesters (2..8)
- ID_W, $clog2(NREQ), requester ID width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept strobe (one-hot or zero)
- req_op  in  2*NREQ  op per requester: 0 ADD, 1 SUB, 2 MUL, 3 reserved
- req_a, req_b  in  16*NREQ  FP16 operands per requester
- ex_valid  out  1  dispatch valid to execution unit
- ex_ready  in  1  execution unit accepts dispatch
- ex_op  out  2  captured op
- ex_a, ex_b  out  16  captured operands
- ex_rsp_valid  in  1  execution unit result valid (single-cycle pulse)
- ex_rsp_result  in  16  execution result
- ex_rsp_flags  in  5  {NV,DZ,OF,UF,NX}
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  granted requester index
- rsp_result  out  16  FP16 result
- rsp_flags  out  5  {NV,DZ,OF,UF,NX}
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, CLASSIFY, DISPATCH, WAIT, RESP.
- IDLE: if any req_valid is high, grant one requester round-robin. Assert req_ready[grant] combinationally in that cycle. Capture op, a, b and id, then go to CLASSIFY. The handshake completes in this cycle, so requesters must hold their inputs while req_valid is high.
- Round-robin: the search starts at last_grant+1 and wraps modulo NREQ. last_grant resets to NREQ-1, so requester 0 wins the first tie.
- CLASSIFY: classify a and b into qNaN, sNaN, zero, inf, subnormal or normal. Go to RESP if a special result applies, otherwise go to DISPATCH.
- Special rules, first match wins. SUB is treated as ADD with b's sign flipped.
  1. op==3 → 0x7E00, NV.
  2. Either operand is sNaN → 0x7E00, NV.
  3. Either operand is qNaN → 0x7E00, flags 0.
  4. ADD with inf + inf of opposite sign → 0x7E00, NV.
  5. ADD with any inf → that inf.
  6. MUL with inf × zero → 0x7E00, NV.
  7. MUL with inf × non-zero → inf, sign = sa^sb.
  8. MUL with zero × finite → zero, sign = sa^sb.
  9. Otherwise dispatch.
- DISPATCH: hold ex_valid high with stable ex_* outputs until ex_ready. Go to WAIT on the cycle ex_valid && ex_ready.
- WAIT: on ex_rsp_valid, latch the result and flags, then go to RESP. ex_rsp_valid in any other state is ignored.
- RESP: hold rsp_valid, rsp_id, rsp_result and rsp_flags stable until rsp_ready. Go to IDLE on the cycle rsp_valid && rsp_ready.
- Only one operation is in flight. req_ready is 0 in every state except IDLE.

## Timing
- Reset values: state IDLE. req_ready, ex_valid, rsp_valid and busy are 0. ex_op, ex_a, ex_b, rsp_id, rsp_result and rsp_flags are 0. last_grant = NREQ-1.
- If a request is accepted in cycle T, CLASSIFY occurs at T+1.
  - Special path: rsp_valid rises at T+2.
  - Execution path: ex_valid rises at T+2. If ex_ready is high at T+2, WAIT starts at T+3.
- If ex_rsp_valid arrives in cycle W, rsp_valid is high at W+1.
- The earliest next accept after response handshake cycle R is R+1.
- If ex_rsp_valid is high in the same cycle as the dispatch handshake, it is ignored. The execution unit's latency is at least 1.
- Asynchronous reset mid-operation: the FSM returns to IDLE immediately and the operation is dropped. A late ex_rsp_valid after reset is ignored.
- All outputs are registered except req_ready.

## Configuration
- Macro: FP16_SPECIAL_BYPASS_EN.
- Defined: special rules 2–8 apply as above.
- Undefined: only rule 1 (op==3) is resolved locally. NaN, inf and zero operands are dispatched, and the execution unit handles all IEEE special cases. The path latency changes accordingly.

## Structure
- Shared package fp16_pkg holds:
  - op encoding enum (ADD, SUB, MUL, RSVD)
  - FSM state enum
  - FP16_CANON_QNAN = 16'h7E00
  - flag bit indices NV=4, DZ=3, OF=2, UF=1, NX=0
  - FP16 class struct
- Sub-module fp16_rr_arb holds the round-robin grant logic (req vector in; grant one-hot, grant index, update strobe). The classification and special-case logic stays inline.

## Test plan
- Reset with rsp_ready=1. Requester 0 issues MUL a=0x7C00, b=0x0000 → 2 cycles later rsp_valid, rsp_id=0, rsp_result=0x7E00, rsp_flags=5'b10000, ex_valid never asserted.
- Requester 1 issues ADD 0x3C00+0x4000, ex_ready=1, execution unit returns 0x4200 with flags 0 after 3 cycles → rsp_result=0x4200, rsp_id=1, rsp_valid one cycle after ex_rsp_valid.
- Both requesters hold back-to-back valid ADDs → grants alternate 0,1,0,1; rsp_id order matches.
- SUB a=0x7C00, b=0x7C00 → 0x7E00 with NV. SUB a=0xFC00, b=0x3C00 → 0xFC00 with flags 0.
- Hold rsp_ready=0 for 5 cycles and ex_ready=0 for 4 cycles → rsp_* and ex_* stay stable, req_ready stays 0, no new grant.
- Assert rst_n=0 while in WAIT, release it, then pulse ex_rsp_valid → no rsp_valid, busy=0, next request accepted normally. Repeat the first scenario with FP16_SPECIAL_BYPASS_EN undefined → ex_valid asserted with ex_a=0x7C00.
